// File: rtl/i2c_slave_phy.sv
// Bit-level I2C slave front end: START/STOP detection, address match, ACK generation,
// write-byte deserialization and read-byte serialization with an open-drain SDA enable.
module i2c_slave_phy #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] dat_o,
  output logic       dat_avail_o,
  output logic       dat_req_o,
  input  logic [7:0] dat_i,
  output logic       start_o,
  output logic       stop_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_WAIT_STOP
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_hist, sda_hist, scl_s, sda_s;
  logic scl_rise, scl_fall, start_det, stop_det, last_bit;
  logic [3:0] bitcnt, bitcnt_nxt;
  logic [7:0] rx_sh, rx_nxt, tx_sh, tx_nxt, dat_nxt, rx_byte;
  logic rw, rw_nxt, sda_oe_nxt, avail_nxt, req_nxt, start_nxt, stop_nxt, busy_nxt;

  // Synchronizers reset to the idle-bus level so reset release never looks like an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_hist <= scl_sync[SYNC_STAGES-1];
      sda_hist <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_hist;
  assign scl_fall  = ~scl_s & scl_hist;
  assign start_det = scl_s & scl_hist & sda_hist & ~sda_s;
  assign stop_det  = scl_s & scl_hist & ~sda_hist & sda_s;
  assign last_bit  = (bitcnt == 4'd7);
  assign rx_byte   = {rx_sh[6:0], sda_s};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start_det)     state_nxt = S_ADDR;
    else if (stop_det) state_nxt = S_IDLE;
    else begin
      case (state)
        S_ADDR:     if (scl_rise && last_bit)
                      state_nxt = (rx_byte[7:1] == SLAVE_ADDR) ? S_ADDR_ACK : S_WAIT_STOP;
        S_ADDR_ACK: if (scl_fall && sda_oe_o) state_nxt = rw ? S_TX : S_RX;
        S_RX:       if (scl_rise && last_bit) state_nxt = S_RX_ACK;
        S_RX_ACK:   if (scl_fall && sda_oe_o) state_nxt = S_RX;
        S_TX:       if (scl_fall && last_bit) state_nxt = S_TX_ACK;
        S_TX_ACK: begin
          if (scl_rise && sda_s) state_nxt = S_WAIT_STOP;
          else if (scl_fall)     state_nxt = S_TX;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // The ACK states use sda_oe_o itself to tell "ACK not yet driven" from "ACK on the bus".
  always_comb begin
    sda_oe_nxt = sda_oe_o;
    dat_nxt    = dat_o;
    avail_nxt  = 1'b0;
    req_nxt    = 1'b0;
    start_nxt  = 1'b0;
    stop_nxt   = 1'b0;
    busy_nxt   = busy_o;
    bitcnt_nxt = bitcnt;
    rx_nxt     = rx_sh;
    tx_nxt     = tx_sh;
    rw_nxt     = rw;
    if (start_det) begin
      sda_oe_nxt = 1'b0;
      bitcnt_nxt = '0;
      rx_nxt     = '0;
      start_nxt  = 1'b1;
      busy_nxt   = 1'b1;
    end else if (stop_det) begin
      sda_oe_nxt = 1'b0;
      bitcnt_nxt = '0;
      stop_nxt   = 1'b1;
      busy_nxt   = 1'b0;
    end else begin
      case (state)
        S_ADDR: if (scl_rise) begin
          rx_nxt     = rx_byte;
          bitcnt_nxt = last_bit ? 4'd0 : bitcnt + 4'd1;
          if (last_bit) rw_nxt = sda_s;
        end
        S_ADDR_ACK: begin
          if (scl_rise && sda_oe_o && rw) req_nxt = 1'b1;
          if (scl_fall) begin
            if (!sda_oe_o) sda_oe_nxt = 1'b1;
            else begin
              bitcnt_nxt = '0;
              if (rw) begin
                tx_nxt     = dat_i;
                sda_oe_nxt = ~dat_i[7];
              end else sda_oe_nxt = 1'b0;
            end
          end
        end
        S_RX: if (scl_rise) begin
          rx_nxt     = rx_byte;
          bitcnt_nxt = last_bit ? 4'd0 : bitcnt + 4'd1;
          if (last_bit) begin
            dat_nxt   = rx_byte;
            avail_nxt = 1'b1;
          end
        end
        S_RX_ACK: if (scl_fall) begin
          sda_oe_nxt = ~sda_oe_o;
          bitcnt_nxt = '0;
        end
        S_TX: if (scl_fall) begin
          if (last_bit) begin
            sda_oe_nxt = 1'b0;
            bitcnt_nxt = '0;
          end else begin
            tx_nxt     = {tx_sh[6:0], 1'b0};
            sda_oe_nxt = ~tx_sh[6];
            bitcnt_nxt = bitcnt + 4'd1;
          end
        end
        S_TX_ACK: begin
          if (scl_rise && !sda_s) req_nxt = 1'b1;
          if (scl_fall) begin
            tx_nxt     = dat_i;
            sda_oe_nxt = ~dat_i[7];
            bitcnt_nxt = '0;
          end
        end
        default: sda_oe_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sda_oe_o    <= 1'b0;
      dat_o       <= '0;
      dat_avail_o <= 1'b0;
      dat_req_o   <= 1'b0;
      start_o     <= 1'b0;
      stop_o      <= 1'b0;
      busy_o      <= 1'b0;
      bitcnt      <= '0;
      rx_sh       <= '0;
      tx_sh       <= '0;
      rw          <= 1'b0;
    end else begin
      sda_oe_o    <= sda_oe_nxt;
      dat_o       <= dat_nxt;
      dat_avail_o <= avail_nxt;
      dat_req_o   <= req_nxt;
      start_o     <= start_nxt;
      stop_o      <= stop_nxt;
      busy_o      <= busy_nxt;
      bitcnt      <= bitcnt_nxt;
      rx_sh       <= rx_nxt;
      tx_sh       <= tx_nxt;
      rw          <= rw_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_slave_phy.sv
// Directed bench for i2c_slave_phy: a bit-banged master on an open-drain bus,
// with queues of expected write bytes and of read bytes handed back on dat_req_o.
module tb_i2c_slave_phy;

  localparam time Q = 50ns;

  logic       clk = 1'b0, rst = 1'b0, scl = 1'b1, msda = 1'b1;
  logic       sda_oe, dat_avail, dat_req, start_p, stop_p, busy, sda_bus;
  logic [7:0] dat_o, dat_i = 8'h00;

  int n_checks = 0, n_fail = 0;
  int start_cnt = 0, stop_cnt = 0, avail_cnt = 0, req_cnt = 0;
  bit oe_seen = 1'b0;
  logic [7:0] exp_wr_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] exp_rd_q[$];
  int s0, p0, a0, r0;

  assign sda_bus = msda & ~sda_oe;

  i2c_slave_phy #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .scl_i(scl), .sda_i(sda_bus), .sda_oe_o(sda_oe),
    .dat_o(dat_o), .dat_avail_o(dat_avail), .dat_req_o(dat_req), .dat_i(dat_i),
    .start_o(start_p), .stop_o(stop_p), .busy_o(busy)
  );

  always #5ns clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor and downstream memory stand-in.
  initial forever begin
    @(negedge clk);
    if (sda_oe) oe_seen = 1'b1;
    if (start_p) start_cnt++;
    if (stop_p) stop_cnt++;
    if (dat_req) begin
      req_cnt++;
      if (rd_q.size() > 0) dat_i = rd_q.pop_front();
    end
    if (dat_avail) begin
      avail_cnt++;
      if (exp_wr_q.size() == 0) check("avail_unexpected", {31'd0, dat_avail}, 32'd0);
      else check("dat_o", {24'd0, dat_o}, {24'd0, exp_wr_q.pop_front()});
    end
  end

  task automatic start_cond();
    #Q msda = 1'b1;
    #Q scl = 1'b1;
    #Q msda = 1'b0;
    #Q scl = 1'b0;
  endtask

  task automatic stop_cond();
    #Q msda = 1'b0;
    #Q scl = 1'b1;
    #Q msda = 1'b1;
    #Q;
  endtask

  task automatic send_bit(input logic b);
    #Q msda = b;
    #Q scl = 1'b1;
    #(2*Q) scl = 1'b0;
  endtask

  task automatic write_byte(input string tag, input logic [7:0] b, input logic exp_ack);
    logic ack;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    #Q msda = 1'b1;
    #Q scl = 1'b1;
    #Q ack = sda_bus;
    #Q scl = 1'b0;
    check(tag, {31'd0, ack}, {31'd0, ~exp_ack});
  endtask

  task automatic read_byte(input string tag, input logic master_ack);
    logic [7:0] b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #Q msda = 1'b1;
      #Q scl = 1'b1;
      #Q b = {b[6:0], sda_bus};
      #Q scl = 1'b0;
    end
    if (exp_rd_q.size() == 0) check({tag, "_noexp"}, 32'd1, 32'd0);
    else check(tag, {24'd0, b}, {24'd0, exp_rd_q.pop_front()});
    send_bit(~master_ack);
  endtask

  task automatic push_rd(input logic [7:0] b);
    rd_q.push_back(b);
    exp_rd_q.push_back(b);
  endtask

  task automatic snap();
    s0 = start_cnt; p0 = stop_cnt; a0 = avail_cnt; r0 = req_cnt;
  endtask

  initial begin
    #3ns rst = 1'b1;
    #100ns rst = 1'b0;
    #20ns;
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dat_o", {24'd0, dat_o}, 32'd0);
    check("rst_pulses", {28'd0, dat_avail, dat_req, start_p, stop_p}, 32'd0);

    // 1: write
    snap();
    start_cond();
    check("t1_busy", {31'd0, busy}, 32'd1);
    write_byte("t1_addr_ack", 8'hA0, 1'b1);
    exp_wr_q.push_back(8'h10); write_byte("t1_ack10", 8'h10, 1'b1);
    exp_wr_q.push_back(8'h55); write_byte("t1_ack55", 8'h55, 1'b1);
    exp_wr_q.push_back(8'hAA); write_byte("t1_ackAA", 8'hAA, 1'b1);
    stop_cond();
    #200ns;
    check("t1_avail_cnt", avail_cnt - a0, 32'd3);
    check("t1_start_cnt", start_cnt - s0, 32'd1);
    check("t1_stop_cnt", stop_cnt - p0, 32'd1);
    check("t1_busy_end", {31'd0, busy}, 32'd0);
    check("t1_dat_o", {24'd0, dat_o}, 32'hAA);

    // 2: address mismatch
    snap();
    oe_seen = 1'b0;
    start_cond();
    write_byte("t2_addr_nack", 8'hA2, 1'b0);
    write_byte("t2_data_nack", 8'h33, 1'b0);
    stop_cond();
    #200ns;
    check("t2_oe_seen", {31'd0, oe_seen}, 32'd0);
    check("t2_avail_cnt", avail_cnt - a0, 32'd0);
    check("t2_stop_cnt", stop_cnt - p0, 32'd1);

    // 3: read with ACK then NACK
    snap();
    push_rd(8'h3C);
    push_rd(8'hC3);
    start_cond();
    write_byte("t3_addr_ack", 8'hA1, 1'b1);
    read_byte("t3_rd0", 1'b1);
    read_byte("t3_rd1", 1'b0);
    oe_seen = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    check("t3_oe_after_nack", {31'd0, oe_seen}, 32'd0);
    stop_cond();
    #200ns;
    check("t3_req_cnt", req_cnt - r0, 32'd2);
    check("t3_busy_end", {31'd0, busy}, 32'd0);

    // 4: repeated START
    snap();
    start_cond();
    write_byte("t4_addr_w", 8'hA0, 1'b1);
    exp_wr_q.push_back(8'h20); write_byte("t4_ack20", 8'h20, 1'b1);
    push_rd(8'h5A);
    start_cond();
    write_byte("t4_addr_r", 8'hA1, 1'b1);
    read_byte("t4_rd", 1'b0);
    stop_cond();
    #200ns;
    check("t4_start_cnt", start_cnt - s0, 32'd2);
    check("t4_dat_o", {24'd0, dat_o}, 32'h20);
    check("t4_req_cnt", req_cnt - r0, 32'd1);

    // 5: abort mid-byte, then a byte with no START must be ignored
    snap();
    start_cond();
    write_byte("t5_addr_ack", 8'hA0, 1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    stop_cond();
    #200ns;
    check("t5_avail_cnt", avail_cnt - a0, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_stop_cnt", stop_cnt - p0, 32'd1);
    #Q scl = 1'b0;
    write_byte("t5_idle_nack", 8'hA0, 1'b0);
    stop_cond();
    #200ns;

    // 6: reset while the address ACK is on the bus
    start_cond();
    for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 5);
    #Q;
    check("t6_ack_driven", {31'd0, sda_oe}, 32'd1);
    rst = 1'b1;
    #1ns;
    check("t6_rst_release", {31'd0, sda_oe}, 32'd0);
    #40ns rst = 1'b0;
    #100ns;
    check("t6_busy_after_rst", {31'd0, busy}, 32'd0);
    snap();
    start_cond();
    write_byte("t6_addr_ack", 8'hA0, 1'b1);
    stop_cond();
    #200ns;
    check("t6_start_cnt", start_cnt - s0, 32'd1);
    check("t6_wr_q_empty", exp_wr_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
